// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle two's-complement adder/subtractor.
// Each RUN cycle adds one CHUNK-bit slice, LSB slice first, and keeps the
// carry between slices in a register. The result and flags are registered
// on the last slice and held until the next operation completes.
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             M,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] ya;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] next_part;
  logic [CHUNK-1:0] cx;
  logic [CHUNK-1:0] cy;
  logic [CHUNK:0]   csum;
  logic             msb_cin;
  logic             accept;
  logic             last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == LAST_IDX);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Current slice sum, partial result with that slice merged in, and the
  // carry into the MSB recovered from the MSB sum bit (a ^ b ^ cin).
  always_comb begin
    cx        = xa[idx*CHUNK +: CHUNK];
    cy        = ya[idx*CHUNK +: CHUNK];
    csum      = {1'b0, cx} + {1'b0, cy} + {{CHUNK{1'b0}}, carry};
    next_part = part;
    next_part[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    msb_cin   = xa[WIDTH-1] ^ ya[WIDTH-1] ^ next_part[WIDTH-1];
  end

  // Control FSM and slice datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      xa    <= '0;
      ya    <= '0;
      part  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            xa    <= x;
            ya    <= y ^ {WIDTH{M}};
            carry <= M;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          part  <= next_part;
          carry <= csum[CHUNK];
          if (last) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Visible result and flags: updated only on the final slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b0;
      N    <= 1'b0;
    end else if (state == RUN && last) begin
      s    <= next_part;
      cout <= csum[CHUNK];
      V    <= msb_cin ^ csum[CHUNK];
      Z    <= ~|next_part;
      N    <= next_part[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: three instances (CHUNK=4, 16, 1) share
// operands and reset; one monitor checks every done pulse against the queue.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M   = 1'b0;
  logic [15:0] x   = '0;
  logic [15:0] y   = '0;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] s_v     [3];
  logic        cout_v  [3];
  logic        v_v     [3];
  logic        z_v     [3];
  logic        n_v     [3];

  localparam int NCHS [3] = '{4, 1, 16};

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t        q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cnt  [3];
  logic [15:0] held [3];

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .M(M), .x(x), .y(y),
    .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]),
    .V(v_v[0]), .Z(z_v[0]), .N(n_v[0]));

  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut_c16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .M(M), .x(x), .y(y),
    .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]),
    .V(v_v[1]), .Z(z_v[1]), .N(n_v[1]));

  seq_addsub #(.WIDTH(16), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .M(M), .x(x), .y(y),
    .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]),
    .V(v_v[2]), .Z(z_v[2]), .N(n_v[2]));

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s inst=%0d actual=%h required=%h", nm, inst, act, req);
    end
  endtask

  // Monitor: checks hold of s while busy, busy length and each result.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt[i]  = 0;
        held[i] = '0;
      end else begin
        if (busy_v[i]) begin
          cnt[i]++;
          chk("hold_s", i, 32'(s_v[i]), 32'(held[i]));
        end
        if (done_v[i]) begin
          chk("done_expected", i, 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("inst",  i, 32'(i),         32'(e.inst));
            chk("s",     i, 32'(s_v[i]),    32'(e.s));
            chk("cout",  i, 32'(cout_v[i]), 32'(e.c));
            chk("V",     i, 32'(v_v[i]),    32'(e.v));
            chk("Z",     i, 32'(z_v[i]),    32'(e.z));
            chk("N",     i, 32'(n_v[i]),    32'(e.n));
            chk("busy_cycles", i, 32'(cnt[i]), 32'(NCHS[i]));
            held[i] = e.s;
          end
          cnt[i] = 0;
        end
      end
    end
  end

  task automatic push_exp(input int inst, input logic [15:0] es,
                          input logic ec, input logic ev,
                          input logic ez, input logic en);
    exp_t e;
    e.inst = 2'(inst);
    e.s = es; e.c = ec; e.v = ev; e.z = ez; e.n = en;
    q.push_back(e);
  endtask

  // Called 1 time unit after a posedge; returns 1 after the accept edge.
  task automatic launch(input int inst, input logic [15:0] xv,
                        input logic [15:0] yv, input logic mv);
    x = xv; y = yv; M = mv;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
  endtask

  task automatic drain(input int inst);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    chk("timeout_pending", inst, 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic op(input int inst, input logic [15:0] xv, input logic [15:0] yv,
                    input logic mv, input logic [15:0] es, input logic ec,
                    input logic ev, input logic ez, input logic en);
    push_exp(inst, es, ec, ev, ez, en);
    launch(inst, xv, yv, mv);
    drain(inst);
  endtask

  task automatic scen2(input int inst);
    op(inst, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    op(inst, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_done", 0, 32'(done_v[0]), 32'd0);
    chk("rst_s",    0, 32'(s_v[0]),    32'd0);
    chk("rst_flags", 0, 32'({cout_v[0], v_v[0], z_v[0], n_v[0]}), 32'd0);
    @(posedge clk); #1;

    // Basic add, inter-chunk carry, overflow, wrap, subtract cases.
    op(0, 16'h0001, 16'h000A, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0);
    op(0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    scen2(0);
    op(0, 16'h0001, 16'h000A, 1'b1, 16'hFFF7, 1'b0, 1'b0, 1'b0, 1'b1);
    op(0, 16'h000B, 16'h000B, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    op(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // start pulsed in the 2nd RUN cycle with other operands is ignored.
    push_exp(0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    launch(0, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    x = 16'hFFFF; y = 16'hFFFF; M = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    drain(0);

    // start held through DONE: back-to-back with no IDLE gap.
    push_exp(0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    push_exp(0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    x = 16'h4000; y = 16'h4000; M = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    x = 16'h0005; y = 16'h0003; M = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (done_v[0]) seen = 1;
    end
    chk("b2b_first_done", 0, 32'(seen), 32'd1);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap_busy", 0, 32'(busy_v[0]), 32'd1);
    drain(0);

    // Reset in the 3rd RUN cycle aborts; no done pulse (no expectation queued).
    launch(0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",  0, 32'(busy_v[0]), 32'd0);
    chk("abort_done",  0, 32'(done_v[0]), 32'd0);
    chk("abort_s",     0, 32'(s_v[0]),    32'd0);
    chk("abort_flags", 0, 32'({cout_v[0], v_v[0], z_v[0], n_v[0]}), 32'd0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;

    // Same overflow/wrap vectors with NCH=1 and NCH=16.
    scen2(1);
    scen2(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
